// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Purpose:
//   Two-master, one-slave arbiter for an Avalon-style memory bus. It lets the
//   CPU instruction-fetch port (m0) and data port (m1) share a single memory
//   that stalls with waitrequest.
//
//   - A grant covers exactly one transfer.
//   - After every transfer the bus passes through one IDLE cycle and is
//     arbitrated again.
//   - A watchdog aborts any grant that stays stalled on waitrequest for too
//     long.
//   - Slave-side outputs are a pure function of the registered owner, so a
//     request raised in cycle N reaches the slave in cycle N+1 at the earliest.
//
// Parameters:
//   PRIORITY_MODE   0 = round-robin between m0/m1
//                   1 = fixed priority, m0 wins every tie
//   TIMEOUT_CYCLES  consecutive stalled cycles tolerated in one grant before
//                   abort (1..65535)
//
// Ports:
//   clk, reset              rising-edge clock; asynchronous active-high reset
//   m0_* / m1_*             master ports: address, read, write, byteenable,
//                           writedata in; readdata, waitrequest out
//   s_*                     slave port: address, read, write, byteenable,
//                           writedata out; readdata, waitrequest in
//   grant                   one-hot owner (01 = m0, 10 = m1, 00 = none)
//   timeout_err             sticky watchdog flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int unsigned PRIORITY_MODE  = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [3:0]  m0_byteenable,
    input  logic [31:0] m0_writedata,
    output logic [31:0] m0_readdata,
    output logic        m0_waitrequest,

    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [3:0]  m1_byteenable,
    input  logic [31:0] m1_writedata,
    output logic [31:0] m1_readdata,
    output logic        m1_waitrequest,

    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [3:0]  s_byteenable,
    output logic [31:0] s_writedata,
    input  logic [31:0] s_readdata,
    input  logic        s_waitrequest,

    output logic [1:0]  grant,
    output logic        timeout_err
);

    // State codes are one-hot, so the grant output is the state register itself.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10
    } state_e;

    typedef enum logic {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } owner_e;

    localparam bit          FIXED_PRIO = (PRIORITY_MODE != 0);
    // The abort fires on the stalled cycle whose count equals this value.
    // The count starts at 0, so this is the TIMEOUT_CYCLES-th stalled cycle.
    localparam logic [15:0] WDOG_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q,       state_d;
    owner_e      last_owner_q,  last_owner_d;
    logic [15:0] wdog_cnt_q,    wdog_cnt_d;
    logic        timeout_err_q, timeout_err_d;

    logic        req0;
    logic        req1;
    logic        own_req;
    owner_e      own_id;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // -------------------------------------------------------------------------
    // Next-state logic: arbitration, completion, protocol drop and watchdog.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        last_owner_d  = last_owner_q;
        wdog_cnt_d    = wdog_cnt_q;
        timeout_err_d = timeout_err_q;
        own_req       = 1'b0;
        own_id        = OWNER_M0;

        case (state_q)
            ST_IDLE: begin
                if (req0 && req1) begin
                    // Round-robin hands a tie to whichever master did not
                    // finish most recently. Fixed priority always favours m0.
                    if (FIXED_PRIO || last_owner_q == OWNER_M1) begin
                        state_d = ST_GNT0;
                    end else begin
                        state_d = ST_GNT1;
                    end
                end else if (req0) begin
                    state_d = ST_GNT0;
                end else if (req1) begin
                    state_d = ST_GNT1;
                end
            end

            ST_GNT0, ST_GNT1: begin
                own_req = (state_q == ST_GNT0) ? req0 : req1;
                own_id  = (state_q == ST_GNT0) ? OWNER_M0 : OWNER_M1;

                if (!own_req) begin
                    // The owner withdrew its request mid-grant. Release the
                    // bus without crediting it as the last owner.
                    state_d = ST_IDLE;
                end else if (!s_waitrequest) begin
                    // The strobe is forwarded and unstalled: the transfer
                    // completes in this cycle.
                    state_d      = ST_IDLE;
                    last_owner_d = own_id;
                end else if (wdog_cnt_q == WDOG_LAST) begin
                    // Abort a stuck transfer. Recording the victim as the
                    // last owner gives the other master the next tie.
                    state_d       = ST_IDLE;
                    last_owner_d  = own_id;
                    timeout_err_d = 1'b1;
                end else begin
                    wdog_cnt_d = wdog_cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The watchdog measures stall time within a single grant only.
        if (state_d != state_q) begin
            wdog_cnt_d = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Bus steering: a pure function of the registered owner, so reset drops
    // the slave strobes at once.
    // -------------------------------------------------------------------------
    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_byteenable   = '0;
        s_writedata    = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;

        case (state_q)
            ST_GNT0: begin
                s_address      = m0_address;
                s_read         = m0_read;
                s_write        = m0_write;
                s_byteenable   = m0_byteenable;
                s_writedata    = m0_writedata;
                m0_waitrequest = s_waitrequest;
            end
            ST_GNT1: begin
                s_address      = m1_address;
                s_read         = m1_read;
                s_write        = m1_write;
                s_byteenable   = m1_byteenable;
                s_writedata    = m1_writedata;
                m1_waitrequest = s_waitrequest;
            end
            default: begin
            end
        endcase
    end

    // Read data is broadcast. Each master qualifies it with its own
    // waitrequest.
    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

    assign grant       = state_q;
    assign timeout_err = timeout_err_q;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: non-blocking assignments make every flop sample pre-edge values,
    // independent of statement or block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            // Resetting to m1 as the last owner lets m0 win the first tie.
            last_owner_q  <= OWNER_M1;
            wdog_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_owner_q  <= last_owner_d;
            wdog_cnt_q    <= wdog_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Purpose:
//   Self-checking bench for mem_bus_arbiter.
//
//   - Two instances share one set of master stimuli:
//       u_rr  round-robin
//       u_fp  fixed priority
//     Each instance has its own stall-counting slave model.
//   - A transaction-level reference tracks the expected owner of each
//     instance. Every cycle, that reference is compared against all DUT
//     outputs.
//   - Directed scenarios add literal expectations for:
//       single read, contention (both modes), write pass-through,
//       watchdog abort, and reset in the middle of a transfer.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int TMO = 16;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] m0_address    = '0;
    logic        m0_read       = 1'b0;
    logic        m0_write      = 1'b0;
    logic [3:0]  m0_byteenable = '0;
    logic [31:0] m0_writedata  = '0;
    logic [31:0] m1_address    = '0;
    logic        m1_read       = 1'b0;
    logic        m1_write      = 1'b0;
    logic [3:0]  m1_byteenable = '0;
    logic [31:0] m1_writedata  = '0;

    // Slave model configuration, shared by both instances.
    logic [31:0] rdata_cfg = '0;
    int          stalls    = 0;
    logic        dead_en   = 1'b0;
    logic [31:0] dead_addr = '0;

    // Per-instance DUT outputs: index 0 = u_rr, index 1 = u_fp.
    logic [31:0] s_addr_a  [2];
    logic        s_read_a  [2];
    logic        s_write_a [2];
    logic [3:0]  s_be_a    [2];
    logic [31:0] s_wd_a    [2];
    logic        s_wait    [2];
    logic [31:0] m0_rd_a   [2];
    logic [31:0] m1_rd_a   [2];
    logic        m0_wait_a [2];
    logic        m1_wait_a [2];
    logic [1:0]  grant_a   [2];
    logic        terr_a    [2];
    int          sl_cnt    [2] = '{0, 0};

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(TMO)) u_rr (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_readdata(m0_rd_a[0]), .m0_waitrequest(m0_wait_a[0]),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_readdata(m1_rd_a[0]), .m1_waitrequest(m1_wait_a[0]),
        .s_address(s_addr_a[0]), .s_read(s_read_a[0]), .s_write(s_write_a[0]),
        .s_byteenable(s_be_a[0]), .s_writedata(s_wd_a[0]),
        .s_readdata(rdata_cfg), .s_waitrequest(s_wait[0]),
        .grant(grant_a[0]), .timeout_err(terr_a[0])
    );

    mem_bus_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(TMO)) u_fp (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_readdata(m0_rd_a[1]), .m0_waitrequest(m0_wait_a[1]),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_readdata(m1_rd_a[1]), .m1_waitrequest(m1_wait_a[1]),
        .s_address(s_addr_a[1]), .s_read(s_read_a[1]), .s_write(s_write_a[1]),
        .s_byteenable(s_be_a[1]), .s_writedata(s_wd_a[1]),
        .s_readdata(rdata_cfg), .s_waitrequest(s_wait[1]),
        .grant(grant_a[1]), .timeout_err(terr_a[1])
    );

    // ---------------------------------------------------------------------
    // Slave model
    //   - Stalls for `stalls` cycles of an active strobe, then accepts the
    //     transfer for one cycle.
    //   - An access to dead_addr (when dead_en is set) stalls forever.
    // ---------------------------------------------------------------------
    function automatic logic slave_wait(input logic strobe, input logic [31:0] addr,
                                        input int cnt, input int n_stall,
                                        input logic dead, input logic [31:0] daddr);
        if (!strobe) return 1'b1;
        if (dead && addr == daddr) return 1'b1;
        return (cnt < n_stall);
    endfunction

    assign s_wait[0] = slave_wait(s_read_a[0] | s_write_a[0], s_addr_a[0], sl_cnt[0],
                                  stalls, dead_en, dead_addr);
    assign s_wait[1] = slave_wait(s_read_a[1] | s_write_a[1], s_addr_a[1], sl_cnt[1],
                                  stalls, dead_en, dead_addr);

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if ((s_read_a[i] | s_write_a[i]) && s_wait[i]) sl_cnt[i] <= sl_cnt[i] + 1;
            else                                         sl_cnt[i] <= 0;
        end
    end

    // ---------------------------------------------------------------------
    // Reference model. It tracks, per instance:
    //   - the owner: -1 none, 0 = m0, 1 = m1
    //   - the last master to finish
    //   - the number of stalled cycles seen in the current grant
    //   - the sticky error flag
    // ---------------------------------------------------------------------
    int    md_owner  [2] = '{-1, -1};
    int    md_last   [2] = '{1, 1};
    int    md_waited [2] = '{0, 0};
    bit    md_terr   [2] = '{1'b0, 1'b0};
    int    md_fixed  [2] = '{0, 1};
    string nm        [2] = '{"rr", "fp"};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic model_reset(input int i);
        md_owner[i]  = -1;
        md_last[i]   = 1;
        md_waited[i] = 0;
        md_terr[i]   = 1'b0;
    endtask

    // Advance one clock edge using the inputs that are stable for this cycle.
    task automatic model_step(input int i);
        bit r0;
        bit r1;
        bit held;
        int o;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        o  = md_owner[i];
        if (o < 0) begin
            if (r0 && r1) md_owner[i] = (md_fixed[i] != 0) ? 0 : 1 - md_last[i];
            else if (r0)  md_owner[i] = 0;
            else if (r1)  md_owner[i] = 1;
            md_waited[i] = 0;
        end else begin
            held = (o == 0) ? r0 : r1;
            if (!held) begin
                md_owner[i] = -1;
            end else if (!s_wait[i]) begin
                md_owner[i] = -1;
                md_last[i]  = o;
            end else begin
                md_waited[i]++;
                if (md_waited[i] >= TMO) begin
                    md_owner[i] = -1;
                    md_last[i]  = o;
                    md_terr[i]  = 1'b1;
                end
            end
            if (md_owner[i] < 0) md_waited[i] = 0;
        end
    endtask

    task automatic compare_one(input int i);
        logic [1:0]  g;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        rd;
        logic        wr;
        logic        w0;
        logic        w1;
        g = '0; a = '0; wd = '0; be = '0; rd = 1'b0; wr = 1'b0; w0 = 1'b1; w1 = 1'b1;
        if (md_owner[i] == 0) begin
            g = 2'b01; a = m0_address; wd = m0_writedata; be = m0_byteenable;
            rd = m0_read; wr = m0_write; w0 = s_wait[i];
        end else if (md_owner[i] == 1) begin
            g = 2'b10; a = m1_address; wd = m1_writedata; be = m1_byteenable;
            rd = m1_read; wr = m1_write; w1 = s_wait[i];
        end
        check({nm[i], " grant"},        32'(grant_a[i]),   32'(g));
        check({nm[i], " s_address"},    s_addr_a[i],       a);
        check({nm[i], " s_read"},       32'(s_read_a[i]),  32'(rd));
        check({nm[i], " s_write"},      32'(s_write_a[i]), 32'(wr));
        check({nm[i], " s_byteenable"}, 32'(s_be_a[i]),    32'(be));
        check({nm[i], " s_writedata"},  s_wd_a[i],         wd);
        check({nm[i], " m0_wait"},      32'(m0_wait_a[i]), 32'(w0));
        check({nm[i], " m1_wait"},      32'(m1_wait_a[i]), 32'(w1));
        check({nm[i], " m0_readdata"},  m0_rd_a[i],        rdata_cfg);
        check({nm[i], " m1_readdata"},  m1_rd_a[i],        rdata_cfg);
        check({nm[i], " timeout_err"},  32'(terr_a[i]),    32'(md_terr[i]));
    endtask

    // Per-cycle comparison on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (reset) model_reset(i);
                compare_one(i);
                if (!reset) model_step(i);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Directed stimulus. A cycle starts 1 time unit after a rising edge.
    // ---------------------------------------------------------------------
    task automatic clear_masters();
        m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_byteenable = '0; m0_writedata = '0;
        m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_byteenable = '0; m1_writedata = '0;
        dead_en = 1'b0;
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        reset = 1'b1;
        clear_masters();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        int          low_cnt;
        int          low_cyc;
        logic [13:0] seq_rr;
        logic [13:0] seq_fp;
        logic [7:0]  rr_m0_done;
        logic [7:0]  rr_m1_done;
        int          fp_m1_low;
        int          gnt_cyc;
        int          done_cnt;
        int          m0_low;
        int          m1_cnt;
        int          m1_cyc;
        int          terr_cyc;

        // Reset values while reset is held.
        @(negedge clk);
        check("reset grant",   32'(grant_a[0]),   32'h0);
        check("reset s_read",  32'(s_read_a[0]),  32'h0);
        check("reset s_write", 32'(s_write_a[0]), 32'h0);
        check("reset m0_wait", 32'(m0_wait_a[0]), 32'h1);
        check("reset m1_wait", 32'(m1_wait_a[0]), 32'h1);
        check("reset terr",    32'(terr_a[0]),    32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // --- Single read, 10 stalls ---------------------------------------
        stalls = 10; rdata_cfg = 32'h8C020004;
        m0_address = 32'hBFC00000; m0_read = 1'b1;
        low_cnt = 0; low_cyc = -1;
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            if (c == 0)  check("A grant c0",   32'(grant_a[0]),   32'h0);
            if (c == 1)  check("A grant c1",   32'(grant_a[0]),   32'h1);
            if (c == 10) check("A m0_wait c10", 32'(m0_wait_a[0]), 32'h1);
            if (c == 12) check("A grant c12",  32'(grant_a[0]),   32'h0);
            if (!m0_wait_a[0]) begin
                low_cnt++; low_cyc = c;
                check("A m0_readdata", m0_rd_a[0], 32'h8C020004);
            end
            @(posedge clk); #1;
            if (low_cyc == c) m0_read = 1'b0;
        end
        check("A wait-low count", 32'(low_cnt), 32'd1);
        check("A completion cycle", 32'(low_cyc), 32'd11);

        // --- Contention, 0 stalls: rr alternates, fp starves m1 -----------
        reset_pulse();
        stalls = 0; rdata_cfg = 32'h11112222;
        m0_address = 32'h00000100; m1_address = 32'h00000200;
        m0_read = 1'b1; m1_read = 1'b1;
        seq_rr = '0; seq_fp = '0; rr_m0_done = '0; rr_m1_done = '0; fp_m1_low = 0;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                seq_rr = {seq_rr[11:0], grant_a[0]};
                seq_fp = {seq_fp[11:0], grant_a[1]};
            end
            if (!m0_wait_a[0]) rr_m0_done[c] = 1'b1;
            if (!m1_wait_a[0]) rr_m1_done[c] = 1'b1;
            if (!m1_wait_a[1]) fp_m1_low++;
            @(posedge clk); #1;
        end
        m0_read = 1'b0; m1_read = 1'b0;
        check("B rr grant sequence", 32'(seq_rr), 32'(14'b01_00_10_00_01_00_10));
        check("B fp grant sequence", 32'(seq_fp), 32'(14'b01_00_01_00_01_00_01));
        check("B rr m0 done cycles", 32'(rr_m0_done), 32'h22);
        check("B rr m1 done cycles", 32'(rr_m1_done), 32'h88);
        check("B fp m1 wait-low count", 32'(fp_m1_low), 32'd0);

        // --- Write pass-through from m1, 8 stalls -------------------------
        reset_pulse();
        stalls = 8; rdata_cfg = 32'h55AA55AA;
        m0_address = 32'hCAFE0000; m0_byteenable = 4'hF; m0_writedata = 32'h12345678;
        m1_address = 32'h00001000; m1_byteenable = 4'b0011; m1_writedata = 32'hDEADBEEF;
        m1_write = 1'b1;
        gnt_cyc = 0; done_cnt = 0; m0_low = 0; low_cyc = -1;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            if (grant_a[0] == 2'b10) gnt_cyc++;
            if (s_write_a[0] && !s_wait[0]) begin
                done_cnt++; low_cyc = c;
            end
            if (!m0_wait_a[0]) m0_low++;
            if (c == 5) begin
                check("C s_address",    s_addr_a[0],          32'h00001000);
                check("C s_byteenable", 32'(s_be_a[0]),       32'h3);
                check("C s_writedata",  s_wd_a[0],            32'hDEADBEEF);
                check("C s_write",      32'(s_write_a[0]),    32'h1);
                check("C s_read",       32'(s_read_a[0]),     32'h0);
            end
            @(posedge clk); #1;
            if (low_cyc == c) m1_write = 1'b0;
        end
        check("C grant cycles", 32'(gnt_cyc), 32'd9);
        check("C completions", 32'(done_cnt), 32'd1);
        check("C completion cycle", 32'(low_cyc), 32'd9);
        check("C m0 wait-low count", 32'(m0_low), 32'd0);

        // --- Watchdog: m0 hits a dead address, m1 queued behind it --------
        reset_pulse();
        stalls = 2; rdata_cfg = 32'h0BADF00D;
        dead_en = 1'b1; dead_addr = 32'hBFC00000;
        m0_address = 32'hBFC00000; m0_read = 1'b1;
        m1_address = 32'h00002000;
        m0_low = 0; m1_cnt = 0; m1_cyc = -1; terr_cyc = -1;
        for (int c = 0; c <= 24; c++) begin
            if (c == 2) m1_read = 1'b1;
            @(negedge clk);
            if (c == 16) begin
                check("D terr c16",  32'(terr_a[0]),  32'h0);
                check("D grant c16", 32'(grant_a[0]), 32'h1);
            end
            if (c == 17) begin
                check("D terr c17",  32'(terr_a[0]),  32'h1);
                check("D grant c17", 32'(grant_a[0]), 32'h0);
            end
            if (c == 18) check("D grant c18", 32'(grant_a[0]), 32'h2);
            if (c == 24) check("D terr sticky", 32'(terr_a[0]), 32'h1);
            if (!m0_wait_a[0]) m0_low++;
            if (!m1_wait_a[0]) begin
                m1_cnt++; m1_cyc = c;
            end
            if (terr_a[0] && terr_cyc < 0) terr_cyc = c;
            @(posedge clk); #1;
            if (terr_cyc == c) m0_read = 1'b0;
            if (m1_cyc == c)   m1_read = 1'b0;
        end
        check("D m0 wait-low count", 32'(m0_low), 32'd0);
        check("D m1 completions", 32'(m1_cnt), 32'd1);
        check("D m1 completion cycle", 32'(m1_cyc), 32'd20);
        check("D timeout first cycle", 32'(terr_cyc), 32'd17);

        // --- Reset during stall 5 of an m1 read ---------------------------
        reset_pulse();
        check("E terr cleared", 32'(terr_a[0]), 32'h0);
        stalls = 10; rdata_cfg = 32'h77778888;
        m1_address = 32'h00003000; m1_read = 1'b1;
        m1_cnt = 0;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (!m1_wait_a[0]) m1_cnt++;
            @(posedge clk); #1;
        end
        check("E s_read before reset", 32'(s_read_a[0]), 32'h1);
        check("E grant before reset",  32'(grant_a[0]),  32'h2);
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check({nm[i], " E s_read in reset"},  32'(s_read_a[i]),  32'h0);
            check({nm[i], " E grant in reset"},   32'(grant_a[i]),   32'h0);
            check({nm[i], " E m1_wait in reset"}, 32'(m1_wait_a[i]), 32'h1);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        m0_address = 32'h00004000; m0_read = 1'b1;
        @(negedge clk);
        check("E grant after release", 32'(grant_a[0]), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("E rr tie after reset", 32'(grant_a[0]), 32'h1);
        check("E fp tie after reset", 32'(grant_a[1]), 32'h1);
        check("E m1 wait-low count", 32'(m1_cnt), 32'd0);
        @(posedge clk); #1;
        clear_masters();

        repeat (4) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
